// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Optional exception-flush input `cancel` is compiled in when MDU_CANCEL_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, serving mthi/mtlo
// MUL   | one shift-add step per cycle
// DIV   | one restoring-division step per cycle
// FIX   | sign correction and HI/LO write-back
module mdu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic             HIWrite,
   input  logic             LOWrite,
`ifdef MDU_CANCEL_EN
   input  logic             cancel,
`endif
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]         state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               op_div;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   opr;
   logic [2*WIDTH-1:0] acc;
   logic               cncl;

`ifdef MDU_CANCEL_EN
   assign cncl = cancel;
`else
   assign cncl = 1'b0;
`endif

   logic             req_signed;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign req_signed = ~MDUOp[0];
   assign mag_a      = (req_signed && A[WIDTH-1]) ? -A : A;
   assign mag_b      = (req_signed && B[WIDTH-1]) ? -B : B;

   // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift[WIDTH-1:0] - opr;
   assign div_ge    = (div_shift >= {1'b0, opr});
   assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
   assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      state_nxt = state;
      if (cncl) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start && !MDUOp[2]) state_nxt = MDUOp[1] ? S_DIV : S_MUL;
            S_MUL:  if (cnt == CW'(1)) state_nxt = S_FIX;
            S_DIV:  if (cnt == CW'(1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         cnt    <= '0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         opr    <= '0;
         acc    <= '0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE);
         if (!cncl) begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (!MDUOp[2]) begin
                        op_div <= MDUOp[1];
                        sign_a <= req_signed & A[WIDTH-1];
                        sign_b <= req_signed & B[WIDTH-1];
                        opr    <= MDUOp[1] ? mag_b : mag_a;
                        acc    <= {{WIDTH{1'b0}}, (MDUOp[1] ? mag_a : mag_b)};
                        cnt    <= CW'(WIDTH);
                     end
                  end else begin
                     if (HIWrite) HI <= A;
                     if (LOWrite) LO <= A;
                  end
               end
               S_MUL: begin
                  acc <= mul_next;
                  cnt <= cnt - CW'(1);
               end
               S_DIV: begin
                  acc <= div_next;
                  cnt <= cnt - CW'(1);
               end
               S_FIX: begin
                  if (op_div) begin
                     LO <= quo_fix;
                     HI <= rem_fix;
                  end else begin
                     {HI, LO} <= prod_fix;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
